// File: rtl/reg_file_io_if.sv
// Purpose: register-file access bus (one write port, two read ports) between the decoder/ALU and reg_file_io.
// Latency: writes commit on the next CLK rising edge; read data is combinational from the read addresses.
// Backpressure: none; every write and read is accepted in the cycle it is presented.
//
// Signals: WE/WADDR/WDATA (write), RADDR_A/RDATA_A and RADDR_B/RDATA_B (reads).
// Modports: master drives addresses and write data; slave (the register file) returns read data.
interface reg_file_io_if #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16
);
  localparam int AW = $clog2(SIZE);

  logic             WE;
  logic [AW-1:0]    WADDR;
  logic [WIDTH-1:0] WDATA;
  logic [AW-1:0]    RADDR_A;
  logic [WIDTH-1:0] RDATA_A;
  logic [AW-1:0]    RADDR_B;
  logic [WIDTH-1:0] RDATA_B;

  modport master (
    output WE, WADDR, WDATA, RADDR_A, RADDR_B,
    input  RDATA_A, RDATA_B
  );

  modport slave (
    input  WE, WADDR, WDATA, RADDR_A, RADDR_B,
    output RDATA_A, RDATA_B
  );
endinterface

// File: rtl/reg_file_io.sv
// Purpose: GP register file with IO_PORTS memory-mapped bidirectional pin ports (DATA/DIR regs, input sync, change detect).
// Latency: write 1 edge; read combinational; pin input readable after SYNC_STAGES edges, PORT_CHG after SYNC_STAGES+1.
// Backpressure: none; accesses are never stalled.
//
// Ports: CLK, RST_N (async active-low), bus (reg_file_io_if.slave), PORT (inout pins,
//        port p = PORT[p*WIDTH +: WIDTH]), PORT_CHG (one-cycle change pulse per port).
// Address map (G = SIZE-2*IO_PORTS): 0..G-1 GP, G+p DATA of port p, G+IO_PORTS+p DIR of port p
// (DIR bit 1 = drive pin). Addresses >= SIZE read 0 and ignore writes.
// Option: define REG_FILE_BYPASS_EN to forward WDATA to a read port addressing the location
// being written in the same cycle; otherwise reads return the pre-write value.
module reg_file_io #(
  parameter int WIDTH       = 8,
  parameter int SIZE        = 16,
  parameter int IO_PORTS    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  reg_file_io_if.slave              bus,
  inout  wire [IO_PORTS*WIDTH-1:0]  PORT,
  output logic [IO_PORTS-1:0]       PORT_CHG
);

  localparam int AW    = $clog2(SIZE);
  localparam int G     = SIZE - 2*IO_PORTS;
  localparam int DEPTH = 2**AW;

  logic [WIDTH-1:0] gp_q   [G];
  logic [WIDTH-1:0] data_q [IO_PORTS];
  logic [WIDTH-1:0] dir_q  [IO_PORTS];
  logic [WIDTH-1:0] sync_q [IO_PORTS][SYNC_STAGES];
  logic [WIDTH-1:0] prev_q [IO_PORTS];
  logic [WIDTH-1:0] pin_in [IO_PORTS];

  // Full power-of-two view of the address space so the read mux never indexes past the end;
  // unmapped slots stay 0.
  logic [WIDTH-1:0] view [DEPTH];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Pin drivers follow DIR directly, so a DIR write turns the driver on right after its edge.
  for (genvar p = 0; p < IO_PORTS; p++) begin : g_port
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign PORT[p*WIDTH + b] = dir_q[p][b] ? data_q[p][b] : 1'bz;
    end
    assign pin_in[p] = PORT[p*WIDTH +: WIDTH];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view[i] = '0;
    end
    for (int g = 0; g < G; g++) begin
      view[g] = gp_q[g];
    end
    for (int p = 0; p < IO_PORTS; p++) begin
      // Output-mode bits read back the latch, input-mode bits the synchronised pin.
      view[G + p]            = (data_q[p] & dir_q[p]) | (sync_q[p][SYNC_STAGES-1] & ~dir_q[p]);
      view[G + IO_PORTS + p] = dir_q[p];
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Per-address forwarding mask: whole word for GP/DIR, only output-mode bits for DATA
  // (input-mode bits of a DATA read come from the pins, not the latch), nothing out of range.
  logic [WIDTH-1:0] byp_mask [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      byp_mask[i] = '0;
    end
    for (int g = 0; g < G; g++) begin
      byp_mask[g] = '1;
    end
    for (int p = 0; p < IO_PORTS; p++) begin
      byp_mask[G + p]            = dir_q[p];
      byp_mask[G + IO_PORTS + p] = '1;
    end
  end

  always_comb begin
    rd_a = view[bus.RADDR_A];
    rd_b = view[bus.RADDR_B];
    if (bus.WE && (bus.WADDR == bus.RADDR_A)) begin
      rd_a = (view[bus.RADDR_A] & ~byp_mask[bus.RADDR_A]) | (bus.WDATA & byp_mask[bus.RADDR_A]);
    end
    if (bus.WE && (bus.WADDR == bus.RADDR_B)) begin
      rd_b = (view[bus.RADDR_B] & ~byp_mask[bus.RADDR_B]) | (bus.WDATA & byp_mask[bus.RADDR_B]);
    end
  end
`else
  always_comb begin
    rd_a = view[bus.RADDR_A];
    rd_b = view[bus.RADDR_B];
  end
`endif

  assign bus.RDATA_A = rd_a;
  assign bus.RDATA_B = rd_b;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int g = 0; g < G; g++) begin
        gp_q[g] <= '0;
      end
      for (int p = 0; p < IO_PORTS; p++) begin
        data_q[p] <= '0;
        dir_q[p]  <= '0;
        prev_q[p] <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[p][s] <= '0;
        end
      end
      PORT_CHG <= '0;
    end else begin
      // Out-of-range addresses match no slot and are silently dropped.
      if (bus.WE) begin
        for (int g = 0; g < G; g++) begin
          if (bus.WADDR == AW'(g)) gp_q[g] <= bus.WDATA;
        end
        for (int p = 0; p < IO_PORTS; p++) begin
          if (bus.WADDR == AW'(G + p))            data_q[p] <= bus.WDATA;
          if (bus.WADDR == AW'(G + IO_PORTS + p)) dir_q[p]  <= bus.WDATA;
        end
      end
      for (int p = 0; p < IO_PORTS; p++) begin
        sync_q[p][0] <= pin_in[p];
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_q[p][s] <= sync_q[p][s-1];
        end
        prev_q[p] <= sync_q[p][SYNC_STAGES-1];
        // dir_q here is the pre-edge value, so a same-edge DIR write does not affect the mask.
        PORT_CHG[p] <= |((sync_q[p][SYNC_STAGES-1] ^ prev_q[p]) & ~dir_q[p]);
      end
    end
  end

endmodule

// File: tb/tb_reg_file_io.sv
// Purpose: directed self-checking bench for reg_file_io (default 16-entry instance plus a 10-entry instance).
// Latency: inputs change 1 ns after each rising edge; outputs are checked before the next edge.
// Backpressure: not applicable.
module tb_reg_file_io;

  logic CLK;
  logic RST_N;

  reg_file_io_if #(.WIDTH(8), .SIZE(16)) bus ();
  reg_file_io_if #(.WIDTH(8), .SIZE(10)) bus_s ();

  wire  [15:0] PORT;
  wire  [15:0] PORT_S;
  logic [1:0]  PORT_CHG;
  logic [1:0]  PORT_CHG_S;

  // Bench-side pin drivers, enabled per bit.
  logic [15:0] tb_en;
  logic [15:0] tb_val;

  for (genvar i = 0; i < 16; i++) begin : g_drv
    assign PORT[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  reg_file_io #(.WIDTH(8), .SIZE(16), .IO_PORTS(2), .SYNC_STAGES(2)) u_dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bus      (bus),
    .PORT     (PORT),
    .PORT_CHG (PORT_CHG)
  );

  reg_file_io #(.WIDTH(8), .SIZE(10), .IO_PORTS(2), .SYNC_STAGES(2)) u_dut_small (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bus      (bus_s),
    .PORT     (PORT_S),
    .PORT_CHG (PORT_CHG_S)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    bus.RADDR_A = a;
    bus.RADDR_B = b;
    #1;
  endtask

  initial begin
    RST_N         = 1'b0;
    bus.WE        = 1'b0;
    bus.WADDR     = '0;
    bus.WDATA     = '0;
    bus.RADDR_A   = '0;
    bus.RADDR_B   = '0;
    bus_s.WE      = 1'b0;
    bus_s.WADDR   = '0;
    bus_s.WDATA   = '0;
    bus_s.RADDR_A = '0;
    bus_s.RADDR_B = '0;
    tb_en         = 16'hFFFF;
    tb_val        = 16'h0000;

    // Reset state
    tick();
    tick();
    rd(4'd3, 4'd14);
    check("reset_gp3", 16'(bus.RDATA_A), 16'h00);
    check("reset_dir0", 16'(bus.RDATA_B), 16'h00);
    check("reset_chg", 16'(PORT_CHG), 16'h0);
    RST_N = 1'b1;
    tick();

    // GP write with same-cycle read, then read on both ports
    bus.WE = 1'b1; bus.WADDR = 4'd3; bus.WDATA = 8'hA5;
    rd(4'd3, 4'd3);
`ifdef REG_FILE_BYPASS_EN
    check("gp3_same_cycle", 16'(bus.RDATA_A), 16'hA5);
`else
    check("gp3_same_cycle", 16'(bus.RDATA_A), 16'h00);
`endif
    tick();
    bus.WE = 1'b0;
    rd(4'd3, 4'd3);
    check("gp3_read_a", 16'(bus.RDATA_A), 16'hA5);
    check("gp3_read_b", 16'(bus.RDATA_B), 16'hA5);

    bus.WE = 1'b1; bus.WADDR = 4'd0; bus.WDATA = 8'h5C;
    tick();
    bus.WE = 1'b0;
    rd(4'd0, 4'd3);
    check("gp0_read_a", 16'(bus.RDATA_A), 16'h5C);
    check("gp3_read_b_again", 16'(bus.RDATA_B), 16'hA5);

    // Port 0: low nibble output. Bench keeps driving 0 until DIR is set, then lets go.
    bus.WE = 1'b1; bus.WADDR = 4'd14; bus.WDATA = 8'h0F;
    tick();
    tb_en = 16'hFFF0;
    bus.WE = 1'b1; bus.WADDR = 4'd12; bus.WDATA = 8'h3C;
    tick();
    bus.WE = 1'b0;
    rd(4'd14, 4'd12);
    check("dir0_read", 16'(bus.RDATA_A), 16'h0F);
    check("data0_read_out_bits", 16'(bus.RDATA_B), 16'h0C);
    check("pins0_low_driven", 16'(PORT[3:0]), 16'hC);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("chg_masked_out_bits", 16'(PORT_CHG), 16'h0);
    end

    // Port 0: external pins [7:4] change to 9
    tb_val[7:4] = 4'h9;
    rd(4'd12, 4'd12);
    check("in0_edge0", 16'(bus.RDATA_A), 16'h0C);
    tick();
    rd(4'd12, 4'd12);
    check("in0_edge1", 16'(bus.RDATA_A), 16'h0C);
    tick();
    rd(4'd12, 4'd12);
    check("in0_edge2", 16'(bus.RDATA_A), 16'h9C);
    check("chg0_edge2", 16'(PORT_CHG), 16'h0);
    tick();
    check("chg0_edge3", 16'(PORT_CHG), 16'h1);
    tick();
    check("chg0_edge4", 16'(PORT_CHG), 16'h0);

    // Output-bit toggle must not raise PORT_CHG
    bus.WE = 1'b1; bus.WADDR = 4'd12; bus.WDATA = 8'h33;
    tick();
    bus.WE = 1'b0;
    check("pins0_low_toggle", 16'(PORT[3:0]), 16'h3);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("chg_after_toggle", 16'(PORT_CHG), 16'h0);
    end
    rd(4'd12, 4'd15);
    check("data0_mixed", 16'(bus.RDATA_A), 16'h93);
    check("dir1_read", 16'(bus.RDATA_B), 16'h00);

    // Port 1, all input: pins change to 0x81
    tb_val[15:8] = 8'h81;
    tick();
    tick();
    rd(4'd13, 4'd13);
    check("in1_edge2", 16'(bus.RDATA_A), 16'h81);
    tick();
    check("chg1_edge3", 16'(PORT_CHG), 16'h2);
    tick();
    check("chg1_edge4", 16'(PORT_CHG), 16'h0);

    // SIZE=10: addresses 10..15 are out of range
    bus_s.WE = 1'b1; bus_s.WADDR = 4'd12; bus_s.WDATA = 8'h77;
    tick();
    bus_s.WADDR = 4'd3; bus_s.WDATA = 8'h5A;
    bus_s.RADDR_A = 4'd3; bus_s.RADDR_B = 4'd12;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("small_gp3_same_cycle", 16'(bus_s.RDATA_A), 16'h5A);
`else
    check("small_gp3_same_cycle", 16'(bus_s.RDATA_A), 16'h00);
`endif
    check("small_oor12", 16'(bus_s.RDATA_B), 16'h00);
    tick();
    bus_s.WE = 1'b0;
    #1;
    check("small_gp3_read", 16'(bus_s.RDATA_A), 16'h5A);
    bus_s.RADDR_B = 4'd15;
    #1;
    check("small_oor15", 16'(bus_s.RDATA_B), 16'h00);

    // Asynchronous reset mid-cycle; a pending write is lost
    bus.WE = 1'b1; bus.WADDR = 4'd0; bus.WDATA = 8'h11;
    rd(4'd3, 4'd14);
    tb_en = 16'hFFFF;
    RST_N = 1'b0;
    #1;
    check("async_rst_gp3", 16'(bus.RDATA_A), 16'h00);
    check("async_rst_dir0", 16'(bus.RDATA_B), 16'h00);
    tick();
    RST_N = 1'b1;
    bus.WE = 1'b0;
    rd(4'd0, 4'd12);
    check("rst_write_lost", 16'(bus.RDATA_A), 16'h00);
    check("rst_chg", 16'(PORT_CHG), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
